// File: rtl/pipelined_rc_adder_pkg.sv
// Shared constants and elaboration helpers for the pipelined ripple-carry adder.
package pipelined_rc_adder_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_SEG   = 4;

  // Pipeline depth: one stage per SEG-bit segment.
  function automatic int stages_of(input int width, input int seg);
    return width / seg;
  endfunction

  // LSB position of segment k inside a full-width operand.
  function automatic int seg_lsb(input int k, input int seg);
    return k * seg;
  endfunction

endpackage

// File: rtl/pipelined_rc_adder_rca_segment.sv
// Combinational SEG-bit ripple-carry adder built from a chain of full adders.
module rca_segment #(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout
);

  logic [SEG:0] carry;

  assign carry[0] = cin;

  for (genvar gi = 0; gi < SEG; gi++) begin : g_fa
    assign sum[gi]     = a[gi] ^ b[gi] ^ carry[gi];
    assign carry[gi+1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
  end

  assign cout = carry[SEG];

endmodule

// File: rtl/pipelined_rc_adder.sv
// Pipelined WIDTH-bit ripple-carry adder, one SEG-bit segment per stage, valid/ready on both sides.
// Define OVF_FLAG_EN to add the registered signed-overflow output ovf.
module pipelined_rc_adder
  import pipelined_rc_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEG   = DEF_SEG
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum_out,
  output logic             C_out
`ifdef OVF_FLAG_EN
  ,
  output logic             ovf
`endif
);

  localparam int STAGES = stages_of(WIDTH, SEG);

  if (WIDTH % SEG != 0) begin : g_bad_cfg
    $error("pipelined_rc_adder: WIDTH (%0d) must be a multiple of SEG (%0d)", WIDTH, SEG);
  end

  logic              adv;
  logic [STAGES-1:0] valid_reg;
  logic [STAGES-1:0] carry_reg;
  logic [STAGES-1:0] carry_next;

  // r_reg holds the unconsumed part of A in its low bits and the completed sum
  // segments in its high bits; every stage shifts it right by SEG, so after the
  // last stage it holds the aligned sum (skew and deskew in one register).
  logic [WIDTH-1:0]  r_reg  [STAGES];
  logic [WIDTH-1:0]  r_next [STAGES];
  logic [WIDTH-1:0]  b_reg  [STAGES];
  logic [WIDTH-1:0]  b_next [STAGES];

`ifdef OVF_FLAG_EN
  logic ovf_reg;
  logic ovf_next;
`endif

  assign adv      = !valid_reg[STAGES-1] || out_ready;
  assign in_ready = adv;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    logic [WIDTH-1:0] src_r;
    logic [WIDTH-1:0] src_b;
    logic             src_c;
    logic [SEG-1:0]   seg_sum;
    logic             seg_cout;

    if (gi == 0) begin : g_src_in
      assign src_r = A;
      assign src_b = B;
      assign src_c = C_in;
    end else begin : g_src_pipe
      assign src_r = r_reg[gi-1];
      assign src_b = b_reg[gi-1];
      assign src_c = carry_reg[gi-1];
    end

    rca_segment #(
      .SEG (SEG)
    ) u_seg (
      .a    (src_r[SEG-1:0]),
      .b    (src_b[SEG-1:0]),
      .cin  (src_c),
      .sum  (seg_sum),
      .cout (seg_cout)
    );

    assign r_next[gi]     = (src_r >> SEG) | (WIDTH'(seg_sum) << (WIDTH - SEG));
    assign b_next[gi]     = src_b >> SEG;
    assign carry_next[gi] = seg_cout;

`ifdef OVF_FLAG_EN
    // In the last stage the low segment of src_r/src_b is the operand MSB segment.
    if (gi == STAGES - 1) begin : g_ovf
      assign ovf_next = (src_r[SEG-1] == src_b[SEG-1]) && (seg_sum[SEG-1] != src_r[SEG-1]);
    end
`endif
  end

  // A stall (adv=0) freezes every stage, bubbles included, so nothing is lost or duplicated.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= '0;
      carry_reg <= '0;
      for (int k = 0; k < STAGES; k++) begin
        r_reg[k] <= '0;
        b_reg[k] <= '0;
      end
    end else if (adv) begin
      valid_reg[0] <= in_valid;
      for (int k = 1; k < STAGES; k++) begin
        valid_reg[k] <= valid_reg[k-1];
      end
      carry_reg <= carry_next;
      for (int k = 0; k < STAGES; k++) begin
        r_reg[k] <= r_next[k];
        b_reg[k] <= b_next[k];
      end
    end
  end

`ifdef OVF_FLAG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_reg <= 1'b0;
    end else if (adv) begin
      ovf_reg <= ovf_next;
    end
  end

  assign ovf = ovf_reg;
`endif

  assign out_valid = valid_reg[STAGES-1];
  assign Sum_out   = r_reg[STAGES-1];
  assign C_out     = carry_reg[STAGES-1];

endmodule
